rf_read_port_arbiter: RTL and testbench
=======================================

# rf_read_port_arbiter

Shares one register-file read port (4-bit source register ID in, 16-bit data out) among NUM_REQ requesters, such as the decode stage, a debug/scan unit and a trace unit. Grants are round-robin. The block drives the register file's source-register ID (which feeds the read wordline decoder), captures the returned data, and returns it to the granted requester under a valid/ready handshake. It sits between the register file and its secondary read clients.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- ID_W, 4, register ID width (16 registers)
- DATA_W, 16, register data width
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester read request
- req_regid  input  NUM_REQ*ID_W  per-requester register ID; requester i uses bits [i*ID_W +: ID_W]
- req_ready  output  NUM_REQ  one-hot (or zero) grant; a transfer happens when req_valid[i] & req_ready[i]
- resp_valid  output  NUM_REQ  one-hot (or zero); response pending for requester i
- resp_data  output  DATA_W  response data, shared by all requesters, valid where resp_valid is set
- resp_ready  input  NUM_REQ  per-requester response accept
- rf_src_reg  output  ID_W  register ID driven to the register-file read port
- rf_src_data  input  DATA_W  register-file read data; combinational from rf_src_reg

## Operation
- States:
  - IDLE: no transaction.
  - ADDR: rf_src_reg is driven and the register file is being read.
  - RESP: resp_valid is held until accepted.
- Grant eligibility ("can_grant"): state==IDLE, or state==RESP with resp_ready[owner]==1.
- Arbitration:
  - Search for a valid requester starting at rr_ptr and moving in ascending order, wrapping modulo NUM_REQ.
  - The first requester with req_valid set wins.
  - req_ready[win] = can_grant; all other bits are 0.
  - req_ready is combinational from req_valid, state, rr_ptr and resp_ready.
- On a grant to requester i:
  - rf_src_reg <= req_regid[i]
  - owner <= i
  - rr_ptr <= (i+1) mod NUM_REQ
  - state <= ADDR
- ADDR → RESP unconditionally:
  - resp_data <= rf_src_data
  - resp_valid <= one-hot(owner)
- RESP, when resp_ready[owner]==1:
  - resp_valid clears.
  - If another grant happens in the same cycle, go to ADDR; otherwise go to IDLE.
- RESP, when resp_ready[owner]==0: hold resp_valid, resp_data and owner stable. No grants are issued.
- resp_ready bits of requesters that are not the owner are ignored.
- rr_ptr changes only on a grant. A requester that drops req_valid before being granted loses nothing.
- rf_src_reg holds its last value outside ADDR. The register file's own write bypass (if any) sets the captured data; the arbiter does not snoop writes.
- Register ID 0 is not special here.

## Timing
- Reset values (cycle after rst sampled high):
  - state=IDLE, rr_ptr=0, owner=0
  - rf_src_reg=0, resp_data=0, resp_valid=0
  - req_ready=0 whenever req_valid=0
- Reset mid-transaction (ADDR or RESP): the pending response is dropped, with no resp_valid pulse afterwards. rst has priority over every other transition.
- Latency:
  - Grant accepted at edge T.
  - rf_src_reg is valid during cycle T+1.
  - resp_valid is high from cycle T+2.
- Throughput: one read per 2 cycles at most. Back-to-back is reached when resp_ready is high in the RESP cycle and a request is pending.
- No grant is possible in the ADDR cycle: req_ready=0 throughout ADDR.
- Simultaneous requests are resolved only by rr_ptr, never by fixed priority.
- Starvation bound: a requester that holds req_valid is granted within NUM_REQ grants.
- Wrap-around: a grant to requester NUM_REQ-1 sets rr_ptr=0.

## Test plan
- Reset then single read:
  - Stimulus: rst 1 for 2 cycles; reg 5 preloaded 0xBEEF; req_valid[2]=1 with regid=5; resp_ready[2]=1.
  - Required: req_ready=0b0100 in cycle 0; rf_src_reg=5 in cycle 1; resp_valid=0b0100 and resp_data=0xBEEF in cycle 2; IDLE in cycle 3.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high; regids 1,2,3,4; resp_ready all 1.
  - Required: grant order 0,1,2,3,0; grants on cycles 0,2,4,6,8; each response carries its own register's data.
- Back-pressure:
  - Stimulus: resp_ready[1]=0 for 5 cycles while requester 1's response is pending; req_valid[3]=1 throughout.
  - Required: resp_valid=0b0010 and resp_data stay stable; req_ready=0 throughout; requester 3 is granted in the same cycle resp_ready[1] rises.
- Wrap and skip:
  - Stimulus: rr_ptr=3 (after a grant to 2); only req_valid[1] is high.
  - Required: requester 1 is granted; rr_ptr becomes 2. Then grant requester 3; rr_ptr becomes 0.
- Reset mid-operation:
  - Stimulus: rst asserted during the ADDR cycle and during a stalled RESP.
  - Required: next cycle has state IDLE, resp_valid=0, rf_src_reg=0, resp_data=0; no late response appears.
- Non-owner resp_ready:
  - Stimulus: resp_ready[0]=1 while requester 2 owns the pending response.
  - Required: no state change; resp_valid stays 0b0100.

Source files
------------

// File: rtl/rf_read_port_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters.
// Each read takes an address cycle and a response cycle held under valid/ready.
module rf_read_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ID_W-1:0] req_regid,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [ID_W-1:0]         rf_src_reg,
    input  logic [DATA_W-1:0]       rf_src_data
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PTR_W-1:0]     rr_ptr_r;
    logic [PTR_W-1:0]     owner_r;
    logic [ID_W-1:0]      rf_src_reg_r;
    logic [DATA_W-1:0]    resp_data_r;
    logic [NUM_REQ-1:0]   resp_valid_r;
    logic [PTR_W-1:0]     win_s;
    logic                 found_s;
    logic                 can_grant_s;
    logic                 grant_s;
    logic                 owner_accept_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin search for the first valid requester at or after rr_ptr
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        found_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        idx_v   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!found_s && req_valid[idx_v]) begin
                found_s = 1'b1;
                win_s   = idx_v;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign owner_accept_s = (state_r == ST_RESP) && resp_ready[owner_r];
    assign can_grant_s    = (state_r == ST_IDLE) || owner_accept_s;
    assign grant_s        = can_grant_s && found_s;

    // Grant is combinational so a new read can start in the same cycle a response is taken
    always_comb begin
        if (grant_s) begin
            req_ready = onehot(win_s);
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Next-state logic for the read sequence
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) state_nxt_s = ST_ADDR;
                else         state_nxt_s = ST_IDLE;
            end
            ST_ADDR: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (owner_accept_s) state_nxt_s = grant_s ? ST_ADDR : ST_IDLE;
                else                state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequential state, grant bookkeeping and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {PTR_W{1'b0}};
            owner_r      <= {PTR_W{1'b0}};
            rf_src_reg_r <= {ID_W{1'b0}};
            resp_data_r  <= {DATA_W{1'b0}};
            resp_valid_r <= {NUM_REQ{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                rf_src_reg_r <= req_regid[int'(win_s)*ID_W +: ID_W];
                owner_r      <= win_s;
                rr_ptr_r     <= (win_s == PTR_W'(NUM_REQ-1)) ? {PTR_W{1'b0}} : win_s + PTR_W'(1);
            end
            if (state_r == ST_ADDR) begin
                resp_data_r  <= rf_src_data;
                resp_valid_r <= onehot(owner_r);
            end else if (owner_accept_s) begin
                resp_valid_r <= {NUM_REQ{1'b0}};
            end
        end
    end

    assign rf_src_reg = rf_src_reg_r;
    assign resp_data  = resp_data_r;
    assign resp_valid = resp_valid_r;

endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// Bench for rf_read_port_arbiter: directed scenarios plus random traffic,
// all checked against a transaction-level model of the read port.
module tb_rf_read_port_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [4*N-1:0] req_regid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  resp_valid;
    logic [15:0]   resp_data;
    logic [N-1:0]  resp_ready;
    logic [3:0]    rf_src_reg;
    logic [15:0]   rf_src_data;
    logic [15:0]   rf [16];

    int n_vec = 0;
    int n_err = 0;

    // model: phase 0 idle, 1 reading, 2 response outstanding
    int          m_phase, m_ptr, m_owner;
    logic [3:0]  m_regid;
    logic [15:0] m_data;

    rf_read_port_arbiter #(.NUM_REQ(N), .ID_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_regid(req_regid), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .rf_src_reg(rf_src_reg), .rf_src_data(rf_src_data)
    );

    assign rf_src_data = rf[rf_src_reg];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner();
        int w = -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (w < 0 && req_valid[j]) w = j;
        end
        return w;
    endfunction

    // check all outputs against the model, then advance one clock
    task automatic step();
        int          w;
        bit          can;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        #1;
        w   = model_winner();
        can = (m_phase == 0) || (m_phase == 2 && resp_ready[m_owner]);
        exp_ready = (can && w >= 0) ? N'(1 << w) : '0;
        exp_rv    = (m_phase == 2) ? N'(1 << m_owner) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_data", 32'(resp_data), 32'(m_data));
        chk("rf_src_reg", 32'(rf_src_reg), 32'(m_regid));
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_regid = '0; m_data = '0;
        end else begin
            if (m_phase == 1) begin
                m_data  = rf[m_regid];
                m_phase = 2;
            end else if (m_phase == 2) begin
                if (resp_ready[m_owner]) m_phase = (exp_ready != 0) ? 1 : 0;
            end else begin
                m_phase = (exp_ready != 0) ? 1 : 0;
            end
            if (exp_ready != 0) begin
                m_regid = req_regid[w*4 +: 4];
                m_owner = w;
                m_ptr   = (w + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] rr);
        req_valid  = v;
        resp_ready = rr;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_regid = '0; resp_ready = '0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i * 16'h0111);
        m_phase = 0; m_ptr = 0; m_owner = 0; m_regid = '0; m_data = '0;
        @(posedge clk); @(negedge clk);
        step(); step();
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        chk("reset_rf_src_reg", 32'(rf_src_reg), 32'h0);
        rst = 1'b0;

        // single read of register 5
        rf[5] = 16'hBEEF;
        req_regid[2*4 +: 4] = 4'd5;
        drive(4'b0100, 4'b0100); #1 chk("single_grant", 32'(req_ready), 32'h4);
        step();
        drive(4'b0000, 4'b0100); #1 chk("single_addr", 32'(rf_src_reg), 32'h5);
        step();
        #1 chk("single_rv", 32'(resp_valid), 32'h4);
        chk("single_data", 32'(resp_data), 32'hBEEF);
        step();
        #1 chk("single_idle", 32'(resp_valid), 32'h0);
        step();

        // wrap and skip: rr_ptr is 3, only requester 1 asks
        drive(4'b0010, 4'b1111); #1 chk("skip_grant1", 32'(req_ready), 32'h2);
        step();
        drive(4'b1010, 4'b1111); #1 chk("addr_no_grant", 32'(req_ready), 32'h0);
        step();
        #1 chk("skip_grant3", 32'(req_ready), 32'h8);
        step();
        drive(4'b0011, 4'b1111); step();
        #1 chk("wrap_grant0", 32'(req_ready), 32'h1);
        step();
        drive(4'b0000, 4'b1111); step(); step(); step();

        // back-pressure on requester 1 while requester 3 waits
        drive(4'b0010, 4'b1111); step();
        drive(4'b1000, 4'b0000); step();
        for (int c = 0; c < 5; c++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_rv", 32'(resp_valid), 32'h2);
            step();
        end
        drive(4'b1000, 4'b0010); #1 chk("bp_release", 32'(req_ready), 32'h8);
        step();
        drive(4'b0000, 4'b1111); step(); step(); step();

        // non-owner resp_ready is ignored
        drive(4'b0100, 4'b0000); step();
        drive(4'b0001, 4'b0001); step();
        for (int c = 0; c < 2; c++) begin
            #1 chk("nonowner_rv", 32'(resp_valid), 32'h4);
            chk("nonowner_ready", 32'(req_ready), 32'h0);
            step();
        end
        drive(4'b0000, 4'b0100); step(); step();

        // round-robin fairness from a fresh reset
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) req_regid[i*4 +: 4] = 4'(i + 1);
        drive(4'b1111, 4'b1111);
        for (int g = 0; g < 5; g++) begin
            #1 chk("rr_order", 32'(req_ready), 32'(1 << (g % N)));
            step();
            step();
            #1 chk("rr_data", 32'(resp_data), 32'(rf[(g % N) + 1]));
        end
        drive(4'b0000, 4'b1111); step(); step();

        // reset during the address cycle
        drive(4'b0001, 4'b0000); step();
        rst = 1'b1; drive(4'b0000, 4'b0000); step(); rst = 1'b0;
        #1 chk("rst_addr_rv", 32'(resp_valid), 32'h0);
        chk("rst_addr_reg", 32'(rf_src_reg), 32'h0);
        step(); step();
        // reset during a stalled response
        drive(4'b0010, 4'b0000); step();
        drive(4'b0000, 4'b0000); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        #1 chk("rst_resp_data", 32'(resp_data), 32'h0);
        step();
        #1 chk("rst_resp_late", 32'(resp_valid), 32'h0);
        step();

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            rst        = ($urandom_range(0, 63) == 0);
            req_valid  = N'($urandom);
            req_regid  = (4*N)'($urandom);
            resp_ready = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            rf[$urandom_range(0, 15)] = 16'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
